// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 3-flop synchroniser, bit-centre sampling, one-cycle rx_flag per good frame.
// Define UART_RX_PARITY_EN for 8E1 framing with an extra parity_err strobe.
`timescale 1ns/1ps

module uart_rx_byte #(
  parameter int BAUD_CNT_MAX = 5208,
  parameter int MID          = BAUD_CNT_MAX / 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rs232_rx,
  output logic [7:0] rx_data,
  output logic       rx_flag
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam logic [12:0] CNT_LAST = 13'(BAUD_CNT_MAX - 1);
  localparam logic [12:0] CNT_MID  = 13'(MID);

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t      state;
  logic        r1, r2, r3;
  logic        rx_s, fall;
  logic [12:0] baud_cnt, baud_next;
  logic [2:0]  bit_cnt;
  logic [7:0]  sr;
  logic        at_mid;
`ifdef UART_RX_PARITY_EN
  logic        par_bit;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r1 <= 1'b1;
      r2 <= 1'b1;
      r3 <= 1'b1;
    end else begin
      r1 <= rs232_rx;
      r2 <= r1;
      r3 <= r2;
    end
  end

  assign rx_s      = r2;
  assign fall      = r3 & ~r2;
  assign at_mid    = (baud_cnt == CNT_MID);
  assign baud_next = (baud_cnt == CNT_LAST) ? 13'd0 : baud_cnt + 13'd1;

  // The count keeps running from the start bit through data and stop so every
  // sample lands a whole number of bit times after the first bit centre.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= WAIT_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      sr       <= '0;
      rx_data  <= '0;
      rx_flag  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      rx_flag <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        WAIT_IDLE: begin
          if (!rx_s) begin
            baud_cnt <= '0;
          end else if (baud_cnt == CNT_LAST) begin
            state    <= IDLE;
            baud_cnt <= '0;
          end else begin
            baud_cnt <= baud_cnt + 13'd1;
          end
        end
        IDLE: begin
          baud_cnt <= '0;
          if (fall) begin
            // the edge-detect cycle itself is count 0 of the start bit
            state    <= START;
            baud_cnt <= 13'd1;
          end
        end
        START: begin
          baud_cnt <= baud_next;
          if (at_mid) begin
            if (!rx_s) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              state    <= IDLE;
              baud_cnt <= '0;
            end
          end
        end
        DATA: begin
          baud_cnt <= baud_next;
          if (at_mid) begin
            sr      <= {rx_s, sr[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          baud_cnt <= baud_next;
          if (at_mid) begin
            par_bit <= rx_s;
            state   <= STOP;
          end
        end
`endif
        STOP: begin
          baud_cnt <= baud_next;
          if (at_mid) begin
            baud_cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
`ifdef UART_RX_PARITY_EN
              if (^{sr, par_bit}) begin
                parity_err <= 1'b1;
              end else begin
                rx_data <= sr;
                rx_flag <= 1'b1;
              end
`else
              rx_data <= sr;
              rx_flag <= 1'b1;
`endif
            end else begin
              state <= WAIT_IDLE;
            end
          end
        end
        default: begin
          state    <= WAIT_IDLE;
          baud_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at 16 clk/bit: table of single frames plus
// back-to-back, glitch and mid-frame reset sequences. Honours UART_RX_PARITY_EN.
`timescale 1ns/1ps

module tb_uart_rx_byte;

  localparam int BAUD = 16;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_LEN = FRAME_BITS * BAUD;
  // 2 synchroniser cycles to the detect cycle, then stop-bit centre, then one register stage
  localparam int FLAG_OFS  = 2 + (FRAME_BITS - 1) * BAUD + BAUD / 2 + 1;
  localparam int GAP       = 24;

  logic       clk;
  logic       rst_n;
  logic       rs232_rx;
  logic [7:0] rx_data;
  logic       rx_flag;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  uart_rx_byte #(.BAUD_CNT_MAX(BAUD), .MID(BAUD / 2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rs232_rx   (rs232_rx),
    .rx_data    (rx_data),
    .rx_flag    (rx_flag)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_compared   = 0;
  int         n_mismatched = 0;
  int         flag_cnt     = 0;
  int         perr_cnt     = 0;
  int         last_flag_cyc = 0;
  int         last_perr_cyc = 0;
  int         flag_cycs[$];
  logic [7:0] flag_datas[$];

  always @(negedge clk) begin
    if (rx_flag === 1'b1) begin
      flag_cnt++;
      last_flag_cyc = cyc;
      flag_cycs.push_back(cyc);
      flag_datas.push_back(rx_data);
    end
`ifdef UART_RX_PARITY_EN
    if (parity_err === 1'b1) begin
      perr_cnt++;
      last_perr_cyc = cyc;
    end
`endif
  end

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic       exp_flag;
    logic [7:0] exp_data;
    logic       exp_perr;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic drive(input logic v, input int n);
    rs232_rx = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic par, input logic stop,
                               output int start);
    start = cyc;
    drive(1'b0, BAUD);
    for (int i = 0; i < 8; i++) drive(d[i], BAUD);
`ifdef UART_RX_PARITY_EN
    drive(par, BAUD);
`else
    if (par === 1'bx) $display("[TB] parity field ignored in 8N1 build");
`endif
    drive(stop, BAUD);
    rs232_rx = 1'b1;
  endtask

  function automatic vec_t mk(input logic [7:0] d, input logic par, input logic stop,
                              input logic ef, input logic [7:0] ed, input logic ep);
    vec_t v;
    v.data = d; v.par = par; v.stop = stop;
    v.exp_flag = ef; v.exp_data = ed; v.exp_perr = ep;
    return v;
  endfunction

  initial begin
    int st, st0, f0, p0, base, idx;
    logic [7:0] bytes[4];
    logic [7:0] b;

    rst_n = 1'b0;
    rs232_rx = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset rx_data", rx_data, 8'h00);
    checkOutput("reset rx_flag", rx_flag, 0);
`ifdef UART_RX_PARITY_EN
    checkOutput("reset parity_err", parity_err, 0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 40);

    // stop=0 vector is a framing error: no strobe, data keeps 0x55
    vecs.push_back(mk(8'h55, 1'b0, 1'b1, 1'b1, 8'h55, 1'b0));
    vecs.push_back(mk(8'hAA, 1'b0, 1'b0, 1'b0, 8'h55, 1'b0));
    vecs.push_back(mk(8'h0F, 1'b0, 1'b1, 1'b1, 8'h0F, 1'b0));
    vecs.push_back(mk(8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0));
    vecs.push_back(mk(8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0));
`ifdef UART_RX_PARITY_EN
    vecs.push_back(mk(8'h55, 1'b0, 1'b1, 1'b1, 8'h55, 1'b0));
    vecs.push_back(mk(8'h55, 1'b1, 1'b1, 1'b0, 8'h55, 1'b1));
    vecs.push_back(mk(8'h01, 1'b1, 1'b1, 1'b1, 8'h01, 1'b0));
`endif

    foreach (vecs[i]) begin
      f0 = flag_cnt;
      p0 = perr_cnt;
      applyStimulus(vecs[i].data, vecs[i].par, vecs[i].stop, st);
      drive(1'b1, GAP);
      checkOutput($sformatf("vec%0d flag count", i), flag_cnt - f0, int'(vecs[i].exp_flag));
      checkOutput($sformatf("vec%0d rx_data", i), rx_data, vecs[i].exp_data);
      if (vecs[i].exp_flag)
        checkOutput($sformatf("vec%0d flag cycle", i), last_flag_cyc - st, FLAG_OFS);
`ifdef UART_RX_PARITY_EN
      checkOutput($sformatf("vec%0d perr count", i), perr_cnt - p0, int'(vecs[i].exp_perr));
      if (vecs[i].exp_perr)
        checkOutput($sformatf("vec%0d perr cycle", i), last_perr_cyc - st, FLAG_OFS);
`else
      checkOutput($sformatf("vec%0d perr count", i), perr_cnt - p0, 0);
`endif
    end

    // back-to-back frames, each stop bit followed directly by the next start bit
    bytes[0] = 8'h12; bytes[1] = 8'h34; bytes[2] = 8'h56; bytes[3] = 8'h78;
    f0 = flag_cnt;
    base = flag_cycs.size();
    st0 = 0;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(bytes[k], ^bytes[k], 1'b1, st);
      if (k == 0) st0 = st;
    end
    drive(1'b1, GAP);
    checkOutput("b2b flag count", flag_cnt - f0, 4);
    for (int k = 0; k < 4; k++) begin
      idx = base + k;
      checkOutput($sformatf("b2b data%0d", k),
                  (idx < flag_datas.size()) ? int'(flag_datas[idx]) : -1, bytes[k]);
      if (k == 0)
        checkOutput("b2b first cycle",
                    (idx < flag_cycs.size()) ? flag_cycs[idx] - st0 : -1, FLAG_OFS);
      else
        checkOutput($sformatf("b2b spacing%0d", k),
                    (idx < flag_cycs.size()) ? flag_cycs[idx] - flag_cycs[idx-1] : -1, FRAME_LEN);
    end

    // 3-cycle low glitch must be rejected at the start-bit centre
    f0 = flag_cnt;
    drive(1'b0, 3);
    drive(1'b1, 30);
    checkOutput("glitch flag count", flag_cnt - f0, 0);
    checkOutput("glitch rx_data", rx_data, 8'h78);
    applyStimulus(8'hAA, ^8'hAA, 1'b1, st);
    drive(1'b1, GAP);
    checkOutput("post-glitch flag count", flag_cnt - f0, 1);
    checkOutput("post-glitch rx_data", rx_data, 8'hAA);
    checkOutput("post-glitch flag cycle", last_flag_cyc - st, FLAG_OFS);

    // reset in the middle of data bit 3; the sender abandons the frame as well
    b = 8'h34;
    f0 = flag_cnt;
    drive(1'b0, BAUD);
    for (int i = 0; i < 3; i++) drive(b[i], BAUD);
    drive(b[3], BAUD / 2);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("mid-frame reset rx_data", rx_data, 8'h00);
    checkOutput("mid-frame reset rx_flag", rx_flag, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(b[3], BAUD / 2 - 2);
    drive(1'b1, GAP);
    checkOutput("aborted frame flag count", flag_cnt - f0, 0);
    checkOutput("aborted frame rx_data", rx_data, 8'h00);
    applyStimulus(8'h56, ^8'h56, 1'b1, st);
    drive(1'b1, GAP);
    checkOutput("post-reset flag count", flag_cnt - f0, 1);
    checkOutput("post-reset rx_data", rx_data, 8'h56);
    checkOutput("post-reset flag cycle", last_flag_cyc - st, FLAG_OFS);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
